// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared encodings for the byte-enable dual-port RAM
package ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_be_merge.sv
// rtl/ram_be_merge.sv - byte-lane merge of a new word over an old word
module ram_be_merge #(
    parameter  int DATA_W = 32,
    parameter  int BYTE_W = 8,
    localparam int NLANE  = DATA_W / BYTE_W
) (
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_word,
    input  logic [NLANE-1:0]  be,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NLANE; i++) begin
            if (be[i]) begin
                merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/ram_dp_be_clr.sv
// rtl/ram_dp_be_clr.sv - simple dual-port RAM with byte enables and post-reset clear sweep
module ram_dp_be_clr
    import ram_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 6,
    parameter  int BYTE_W     = 8,
    parameter  int RDW_MODE   = 0,
    parameter  int CLR_ON_RST = 1,
    localparam int NLANE      = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NLANE-1:0]  wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;
    logic [DATA_W-1:0] merged;
    logic              collision;

    // One merge serves both paths: on a collision the old word of the
    // write address is the old word of the read address.
    ram_be_merge #(
        .DATA_W(DATA_W),
        .BYTE_W(BYTE_W)
    ) u_merge (
        .old_word(mem[wr_addr]),
        .new_word(wr_data),
        .be      (wr_be),
        .merged  (merged)
    );

    assign busy      = (state == ST_CLEAR);
    assign collision = rd_en && wr_en && (rd_addr == wr_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        if (state == ST_CLEAR) begin
            clr_ptr_nxt = clr_ptr + 1'b1;
            if (clr_ptr == {ADDR_W{1'b1}}) begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Array has no reset; the sweep owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (busy) begin
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            if (RDW_MODE == RDW_WRITE_FIRST && collision) begin
                rd_data <= merged;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_dp_be_clr.sv
// tb/tb_ram_dp_be_clr.sv - directed self-checking bench for ram_dp_be_clr (both read-during-write modes)
module tb_ram_dp_be_clr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dp_be_clr #(.DATA_W(32), .ADDR_W(6), .BYTE_W(8), .RDW_MODE(0), .CLR_ON_RST(1)) u_rf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .busy(busy0)
    );

    ram_dp_be_clr #(.DATA_W(32), .ADDR_W(6), .BYTE_W(8), .RDW_MODE(1), .CLR_ON_RST(1)) u_wf (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read(input logic [5:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    // Counts cycles until busy drops, bounded so a stuck sweep cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h0101_0101 * i + 32'h1000_0000;
    endfunction

    initial begin
        int n;
        logic bad;

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
        tick();
        tick();
        check("reset_rd_data",  rd_data0, 32'h0);
        check("reset_rd_valid", {31'b0, rd_valid0 | rd_valid1}, 32'h0);
        check("reset_busy",     {31'b0, busy0 & busy1}, 32'h1);

        // Requests during the sweep must be ignored
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 6'd3;
        rst = 1'b0;
        bad = 1'b0;
        n = 0;
        while (busy0 && n < 200) begin
            tick();
            n++;
            bad |= rd_valid0 | rd_valid1 | (rd_data0 != 0) | (rd_data1 != 0);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("first_sweep_len", n, 64);
        check("busy1_dropped", {31'b0, busy1}, 32'h0);
        check("no_valid_while_busy", {31'b0, bad}, 32'h0);
        read(6'd3);
        check("addr3_after_busy_v", {31'b0, rd_valid0}, 32'h1);
        check("addr3_after_busy_0", rd_data0, 32'h0);
        check("addr3_after_busy_1", rd_data1, 32'h0);

        // Preload non-zero data, then reset with a second reset mid-sweep
        for (int i = 0; i < 64; i++) write(6'(i), 32'hA500_0000 | i, 4'hF);
        read(6'd10);
        check("preload_addr10", rd_data0, 32'hA500_000A);
        rst = 1'b1;
        #1;
        check("rst_kills_valid", {31'b0, rd_valid0}, 32'h0);
        check("rst_rd_data_zero", rd_data0, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("busy_at_cycle20", {31'b0, busy0}, 32'h1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        count_busy(n);
        check("restarted_sweep_len", n, 64);
        for (int i = 0; i < 64; i++) begin
            read(6'(i));
            check($sformatf("cleared_%0d_rf", i), rd_data0, 32'h0);
            check($sformatf("cleared_%0d_wf", i), rd_data1, 32'h0);
        end

        // Byte-enable merge and read latency
        write(6'd5, 32'hDEAD_BEEF, 4'b1111);
        write(6'd5, 32'h1122_3344, 4'b0101);
        rd_en = 1'b1; rd_addr = 6'd5;
        #1;
        check("valid_before_edge", {31'b0, rd_valid0}, 32'h0);
        tick();
        rd_en = 1'b0;
        check("be_merge_valid", {31'b0, rd_valid0 & rd_valid1}, 32'h1);
        check("be_merge_rf", rd_data0, 32'hDE22_BE44);
        check("be_merge_wf", rd_data1, 32'hDE22_BE44);
        tick();
        check("valid_one_cycle", {31'b0, rd_valid0 | rd_valid1}, 32'h0);
        check("rd_data_holds", rd_data0, 32'hDE22_BE44);
        write(6'd5, 32'h0000_0000, 4'b0000);
        read(6'd5);
        check("be_zero_no_change", rd_data0, 32'hDE22_BE44);

        // Same-address collision in both modes
        write(6'd9, 32'hAAAA_AAAA, 4'hF);
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 32'h5555_5555; wr_be = 4'b0011;
        rd_en = 1'b1; rd_addr = 6'd9;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("collision_read_first", rd_data0, 32'hAAAA_AAAA);
        check("collision_write_first", rd_data1, 32'hAAAA_5555);
        read(6'd9);
        check("after_collision_rf", rd_data0, 32'hAAAA_5555);
        check("after_collision_wf", rd_data1, 32'hAAAA_5555);

        // Different addresses do not interact
        wr_en = 1'b1; wr_addr = 6'd12; wr_data = 32'h1234_5678; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 6'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("diff_addr_rf", rd_data0, 32'hDE22_BE44);
        check("diff_addr_wf", rd_data1, 32'hDE22_BE44);

        // Streaming reads over the full address range
        for (int i = 0; i < 64; i++) write(6'(i), pat(i), 4'hF);
        rd_en = 1'b1; rd_addr = 6'd0;
        for (int i = 0; i < 64; i++) begin
            tick();
            rd_addr = 6'(i + 1);
            check($sformatf("stream_valid_%0d", i), {31'b0, rd_valid0 & rd_valid1}, 32'h1);
            check($sformatf("stream_data_%0d", i), rd_data0, pat(i));
        end
        rd_en = 1'b0;
        tick();
        check("stream_end_valid", {31'b0, rd_valid0 | rd_valid1}, 32'h0);
        check("stream_end_hold", rd_data1, pat(63));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
